// File: rtl/video_pkg.sv
// Shared types and helpers for the video frame arbiter.
package video_pkg;

    // Arbiter FSM: IDLE picks an owner, HUNT drops beats until start-of-frame,
    // XFER streams the frame through until FRAME_LINES tlasts have been seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        XFER = 2'd2
    } vid_state_t;

    // Bits needed to hold a line count from 0 up to and including 'lines'.
    function automatic int line_cnt_width(input int lines);
        int w;
        w = $clog2(lines + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/axis_vid_mux.sv
// 2:1 AXI-Stream video mux with ready steering. The select comes straight
// from the owner flop in the top level, so the data path is purely
// combinational and adds no latency.
module axis_vid_mux #(
    parameter int D_WIDTH = 8
) (
    input  logic               sel,
    input  logic               active,
    input  logic               hunt,
    input  logic [D_WIDTH-1:0] s0_data,
    input  logic               s0_valid,
    input  logic               s0_tlast,
    input  logic               s0_tuser,
    output logic               s0_ready,
    input  logic [D_WIDTH-1:0] s1_data,
    input  logic               s1_valid,
    input  logic               s1_tlast,
    input  logic               s1_tuser,
    output logic               s1_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready,
    output logic               fwd_hs,
    output logic               drop_hs
);

    logic               g_valid;
    logic               g_tlast;
    logic               g_tuser;
    logic               g_ready;
    logic               fwd;
    logic [D_WIDTH-1:0] g_data;

    // Select the owner's beat; while hunting, only a tuser beat is forwarded,
    // anything else is accepted and discarded so the owner can catch up.
    always_comb begin
        g_valid    = sel ? s1_valid : s0_valid;
        g_data     = sel ? s1_data  : s0_data;
        g_tlast    = sel ? s1_tlast : s0_tlast;
        g_tuser    = sel ? s1_tuser : s0_tuser;
        fwd        = active && (!hunt || g_tuser);
        down_valid = fwd && g_valid;
        down_data  = g_data;
        down_tlast = g_tlast;
        down_tuser = g_tuser;
        g_ready    = active && (fwd ? down_ready : 1'b1);
        s0_ready   = g_ready && !sel;
        s1_ready   = g_ready && sel;
        fwd_hs     = down_valid && down_ready;
        drop_hs    = active && hunt && g_valid && !g_tuser;
    end

endmodule

// File: rtl/video_frame_arbiter.sv
// Frame-granular arbiter between two AXI-Stream video sources feeding one
// downscaler. Ownership only changes between frames; a new owner's stream is
// resynchronised on tuser before any beat is forwarded.
module video_frame_arbiter
    import video_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int FRAME_LINES = 1080
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] s0_data,
    input  logic               s0_valid,
    input  logic               s0_tlast,
    input  logic               s0_tuser,
    output logic               s0_ready,
    input  logic [D_WIDTH-1:0] s1_data,
    input  logic               s1_valid,
    input  logic               s1_tlast,
    input  logic               s1_tuser,
    output logic               s1_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready,
    output logic               grant_valid,
    output logic               grant_id,
    output logic               frame_done,
    output logic               sof_err,
    output logic [15:0]        drop_cnt
);

    localparam int            LW        = line_cnt_width(FRAME_LINES);
    localparam logic [LW-1:0] LINES_END = LW'(FRAME_LINES);

    vid_state_t    state_q, state_d;
    logic          rr_q, rr_d;
    logic          gid_q, gid_d;
    logic [LW-1:0] line_q, line_d, line_next;
    logic [15:0]   drop_q, drop_d;
    logic          done_q, done_d;
    logic          sof_q, sof_d;
    logic          fwd_hs;
    logic          drop_hs;

    assign grant_valid = (state_q != IDLE);
    assign grant_id    = gid_q;
    assign frame_done  = done_q;
    assign sof_err     = sof_q;
    assign drop_cnt    = drop_q;

    axis_vid_mux #(.D_WIDTH(D_WIDTH)) u_mux (
        .sel        (gid_q),
        .active     (grant_valid),
        .hunt       (state_q == HUNT),
        .s0_data    (s0_data),
        .s0_valid   (s0_valid),
        .s0_tlast   (s0_tlast),
        .s0_tuser   (s0_tuser),
        .s0_ready   (s0_ready),
        .s1_data    (s1_data),
        .s1_valid   (s1_valid),
        .s1_tlast   (s1_tlast),
        .s1_tuser   (s1_tuser),
        .s1_ready   (s1_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_tlast (down_tlast),
        .down_tuser (down_tuser),
        .down_ready (down_ready),
        .fwd_hs     (fwd_hs),
        .drop_hs    (drop_hs)
    );

    // Next-state: arbitration in IDLE, drop counting in HUNT, line tracking
    // on every forwarded beat. A forwarded tuser always restarts the line
    // count, which also covers the HUNT->XFER entry.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        line_d    = line_q;
        drop_d    = drop_q;
        done_d    = 1'b0;
        sof_d     = 1'b0;
        line_next = (down_tuser ? '0 : line_q) + LW'(down_tlast);
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    gid_d   = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    line_d  = '0;
                    state_d = HUNT;
                end
            end
            HUNT, XFER: begin
                if (drop_hs && drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
                if (fwd_hs) begin
                    if (state_q == XFER && down_tuser)
                        sof_d = 1'b1;
                    if (down_tlast && line_next == LINES_END) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        rr_d    = ~gid_q;
                        line_d  = '0;
                    end else begin
                        state_d = XFER;
                        line_d  = line_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, round-robin pointer, counters and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gid_q   <= 1'b0;
            line_q  <= '0;
            drop_q  <= '0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            line_q  <= line_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
            sof_q   <= sof_d;
        end
    end

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Self-checking bench for video_frame_arbiter: FRAME_LINES=2, 4-pixel lines.
module tb_video_frame_arbiter;

    localparam int DW = 8;
    localparam int FL = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          tlast;
        logic          tuser;
    } beat_t;

    typedef struct {
        int    f0, f1, g0, g1, inj, stall;
        int    e_beats, e_done, e_sof, e_drop, e_gid0;
        string name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s0_data = '0, s1_data = '0;
    logic          s0_valid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0;
    logic          s1_valid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0;
    logic          s0_ready, s1_ready;
    logic [DW-1:0] down_data;
    logic          down_valid, down_tlast, down_tuser;
    logic          down_ready = 1'b0;
    logic          grant_valid, grant_id, frame_done, sof_err;
    logic [15:0]   drop_cnt;

    video_frame_arbiter #(.D_WIDTH(DW), .FRAME_LINES(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_tlast(s0_tlast),
        .s0_tuser(s0_tuser), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_tlast(s1_tlast),
        .s1_tuser(s1_tuser), .s1_ready(s1_ready),
        .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
        .down_tuser(down_tuser), .down_ready(down_ready),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .frame_done(frame_done), .sof_err(sof_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    beat_t q0[$], q1[$];      // source streams still to be offered
    beat_t m0[$], m1[$];      // model's working copies
    beat_t got[$], exp_q[$];
    int    gids[$], exp_gids[$];
    int    done_n, sof_n, viol, exp_done, exp_sof, exp_drop;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // One frame = 2 lines x 4 pixels. 'garbage' tuser=0 beats come first;
    // 'inj' >= 0 prepends that many beats of an aborted frame, so the real
    // frame's tuser lands mid-frame at beat index 'inj'.
    task automatic add_frame(input int who, input int garbage, input int inj);
        beat_t b;
        for (int i = 0; i < garbage; i++) begin
            b.data = DW'($urandom); b.tlast = 1'($urandom); b.tuser = 1'b0;
            if (who == 0) q0.push_back(b); else q1.push_back(b);
        end
        for (int i = 0; i < inj; i++) begin
            b.data = DW'($urandom); b.tlast = (i % 4 == 3); b.tuser = (i == 0);
            q0.push_back(b);
        end
        for (int i = 0; i < 8; i++) begin
            b.data = DW'($urandom); b.tlast = (i % 4 == 3); b.tuser = (i == 0);
            if (who == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    function automatic int msize(input int w);
        return (w == 0) ? m0.size() : m1.size();
    endfunction

    task automatic mpop(input int w, output beat_t b);
        if (w == 0) b = m0.pop_front(); else b = m1.pop_front();
    endtask

    // Reference: walk both streams a frame at a time. Whenever both sources
    // have data the round-robin pointer decides, otherwise whoever has data.
    task automatic model();
        int    rr, own, lines, started, done;
        beat_t b;
        m0 = q0; m1 = q1;
        exp_q.delete(); exp_gids.delete();
        exp_done = 0; exp_sof = 0; exp_drop = 0; rr = 0;
        while (m0.size() + m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) own = rr;
            else own = (m0.size() > 0) ? 0 : 1;
            while (msize(own) > 0 && ((own == 0) ? !m0[0].tuser : !m1[0].tuser)) begin
                mpop(own, b);
                if (exp_drop < 65535) exp_drop++;
            end
            lines = 0; started = 0; done = 0;
            while (msize(own) > 0 && done == 0) begin
                mpop(own, b);
                exp_q.push_back(b);
                if (b.tuser) begin
                    if (started != 0) exp_sof++;
                    lines = 0;
                end
                started = 1;
                if (b.tlast) lines++;
                if (lines == FL) done = 1;
            end
            if (done == 0) break;
            exp_done++;
            exp_gids.push_back(own);
            rr = 1 - own;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offer queued beats, sample at the falling edge, pop what was accepted.
    // stop_after >= 0 ends the run once that many beats have come out.
    task automatic run(input int stall, input int stop_after, output int timed_out);
        int cyc, tail;
        bit h0, h1;
        got.delete(); gids.delete();
        done_n = 0; sof_n = 0; viol = 0; cyc = 0; tail = 0; timed_out = 0;
        while (1) begin
            s0_valid = (q0.size() > 0);
            if (s0_valid) {s0_data, s0_tlast, s0_tuser} = q0[0];
            else {s0_data, s0_tlast, s0_tuser} = '0;
            s1_valid = (q1.size() > 0);
            if (s1_valid) {s1_data, s1_tlast, s1_tuser} = q1[0];
            else {s1_data, s1_tlast, s1_tuser} = '0;
            down_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            h0 = s0_valid && s0_ready;
            h1 = s1_valid && s1_ready;
            if (down_valid && down_ready) got.push_back({down_data, down_tlast, down_tuser});
            if (frame_done) begin done_n++; gids.push_back(int'(grant_id)); end
            if (sof_err) sof_n++;
            if (!grant_valid && (s0_ready || s1_ready || down_valid)) viol++;
            if (grant_valid && (grant_id ? s0_ready : s1_ready)) viol++;
            if (down_valid && {down_data, down_tlast, down_tuser} !=
                (grant_id ? {s1_data, s1_tlast, s1_tuser} : {s0_data, s0_tlast, s0_tuser}))
                viol++;
            @(posedge clk); #1;
            if (h0) void'(q0.pop_front());
            if (h1) void'(q1.pop_front());
            cyc++;
            if (stop_after >= 0 && got.size() >= stop_after) break;
            if (q0.size() == 0 && q1.size() == 0) tail++;
            if (tail > 4) break;
            if (cyc >= 3000) begin timed_out = 1; break; end
        end
    endtask

    task automatic check_against_model(input string nm, input int to);
        int mism, gm;
        chk({nm, " timeout"}, to, 0);
        chk({nm, " beat_count"}, got.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) mism++;
        chk({nm, " beat_mismatches"}, mism, 0);
        chk({nm, " frame_done"}, done_n, exp_done);
        chk({nm, " sof_err"}, sof_n, exp_sof);
        chk({nm, " drop_cnt"}, int'(drop_cnt), exp_drop);
        gm = (gids.size() == exp_gids.size()) ? 0 : 1;
        for (int i = 0; i < gids.size() && i < exp_gids.size(); i++)
            if (gids[i] != exp_gids[i]) gm++;
        chk({nm, " grant_order"}, gm, 0);
        chk({nm, " protocol_violations"}, viol, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int to;

        //          f0 f1 g0 g1 inj st beats done sof drop gid0
        vecs[0] = '{1, 0, 0, 0, -1, 0,  8, 1, 0, 0, 0, "s0_only"};
        vecs[1] = '{3, 3, 0, 0, -1, 0, 48, 6, 0, 0, 0, "both_rr"};
        vecs[2] = '{0, 1, 0, 3, -1, 0,  8, 1, 0, 3, 1, "s1_drop"};
        vecs[3] = '{1, 0, 0, 0,  5, 0, 13, 1, 1, 0, 0, "sof_inject"};
        vecs[4] = '{3, 3, 0, 0, -1, 1, 48, 6, 0, 0, 0, "both_stall"};
        vecs[5] = '{2, 1, 0, 2, -1, 1, 24, 3, 0, 2, 0, "mixed_drop"};

        // Reset state with both sources requesting.
        rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1; down_ready = 1'b1;
        #22;
        chk("reset readies", int'({s0_ready, s1_ready}), 0);
        chk("reset down_valid", int'(down_valid), 0);
        chk("reset grant", int'({grant_valid, grant_id}), 0);
        chk("reset drop_cnt", int'(drop_cnt), 0);
        chk("reset pulses", int'({frame_done, sof_err}), 0);

        // Directed table.
        foreach (vecs[v]) begin
            do_reset();
            q0.delete(); q1.delete();
            for (int k = 0; k < vecs[v].f0; k++)
                add_frame(0, (k == 0) ? vecs[v].g0 : 0, (k == 0) ? vecs[v].inj : -1);
            for (int k = 0; k < vecs[v].f1; k++)
                add_frame(1, (k == 0) ? vecs[v].g1 : 0, -1);
            model();
            run(vecs[v].stall, -1, to);
            check_against_model(vecs[v].name, to);
            chk({vecs[v].name, " tbl_beats"}, got.size(), vecs[v].e_beats);
            chk({vecs[v].name, " tbl_done"}, done_n, vecs[v].e_done);
            chk({vecs[v].name, " tbl_sof"}, sof_n, vecs[v].e_sof);
            chk({vecs[v].name, " tbl_drop"}, int'(drop_cnt), vecs[v].e_drop);
            chk({vecs[v].name, " tbl_gid0"}, (gids.size() > 0) ? gids[0] : -1, vecs[v].e_gid0);
        end

        // Randomised streams, random stalls.
        for (int it = 0; it < 6; it++) begin
            int f0, f1;
            do_reset();
            q0.delete(); q1.delete();
            f0 = $urandom_range(0, 3);
            f1 = $urandom_range((f0 == 0) ? 1 : 0, 3);
            for (int k = 0; k < f0; k++) add_frame(0, (k == 0) ? $urandom_range(0, 3) : 0, -1);
            for (int k = 0; k < f1; k++) add_frame(1, (k == 0) ? $urandom_range(0, 3) : 0, -1);
            model();
            run(int'($urandom_range(0, 1)), -1, to);
            check_against_model($sformatf("rand%0d", it), to);
        end

        // Reset mid-frame: move rr to 1, abandon an s0 frame at beat 4,
        // then confirm the pointer came back to 0.
        do_reset();
        q0.delete(); q1.delete();
        add_frame(0, 0, -1);
        run(0, -1, to);
        chk("midrst first frame_done", done_n, 1);
        add_frame(0, 0, -1);
        run(0, 4, to);
        chk("midrst partial beats", got.size(), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst readies", int'({s0_ready, s1_ready}), 0);
        chk("midrst down_valid", int'(down_valid), 0);
        chk("midrst grant_valid", int'(grant_valid), 0);
        chk("midrst no frame_done", done_n + int'(frame_done), 0);
        s0_valid = 1'b0; s1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst idle", int'({grant_valid, frame_done, sof_err}), 0);
        chk("postrst drop_cnt", int'(drop_cnt), 0);
        @(posedge clk); #1;
        q0.delete(); q1.delete();
        add_frame(0, 0, -1);
        add_frame(1, 0, -1);
        model();
        run(0, -1, to);
        check_against_model("postrst rr", to);
        chk("postrst first owner", (gids.size() > 0) ? gids[0] : -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_frame_arbiter.md
VIDEO_FRAME_ARBITER -- requirements
Module: video_frame_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel data width.
REQ-002 SHALL have parameter FRAME_LINES, default 1080, lines (tlast beats) per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports s0_data/s0_valid/s0_tlast/s0_tuser  input  D_WIDTH/1/1/1  requester 0 AXI-Stream video; s0_ready  output  1.
REQ-006 SHALL have ports s1_data/s1_valid/s1_tlast/s1_tuser  input  D_WIDTH/1/1/1  requester 1, same semantics; s1_ready  output  1.
REQ-007 SHALL have ports down_data/down_valid/down_tlast/down_tuser  output  D_WIDTH/1/1/1  to downscaler; down_ready  input  1.
REQ-008 SHALL have port grant_valid  output  1  high in HUNT or XFER.
REQ-009 SHALL have port grant_id  output  1  requester currently owning the downscaler.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse per completed frame.
REQ-011 SHALL have port sof_err  output  1  one-cycle pulse on tuser received mid-frame.
REQ-012 SHALL have port drop_cnt  output  16  saturating count of beats discarded while hunting.

Function
REQ-013 SHALL implement FSM states IDLE, HUNT, XFER; ownership changes only in IDLE (frame granularity).
REQ-014 IDLE: s0_ready=s1_ready=0, down_valid=0; no beat transferred.
REQ-015 IDLE with exactly one sN_valid high SHALL grant N and enter HUNT next cycle.
REQ-016 IDLE with both valid SHALL grant requester indicated by round-robin pointer rr; none valid -> stay IDLE.
REQ-017 HUNT, granted beat tuser=0: granted ready=1, down_valid=0, beat dropped, drop_cnt+1 (saturate at 0xFFFF).
REQ-018 HUNT, granted beat tuser=1: beat forwarded as in XFER; on handshake enter XFER, line counter = (tlast?1:0).
REQ-019 XFER: combinational pass-through, zero latency: down_* = granted s*_*, granted ready = down_ready, non-granted ready = 0.
REQ-020 Line counter SHALL increment on each forwarded tlast handshake; width ceil(log2(FRAME_LINES+1)).
REQ-021 Handshake of tlast making count == FRAME_LINES SHALL end frame: next state IDLE, frame_done pulse next cycle, rr = ~grant_id.
REQ-022 FRAME_LINES=1: a tuser+tlast handshake in HUNT SHALL complete the frame directly (HUNT -> IDLE).
REQ-023 XFER, forwarded beat with tuser=1: beat still forwarded, sof_err pulse next cycle, line counter restarts at (tlast?1:0); ownership kept.
REQ-024 Non-granted requester SHALL be held (ready=0) indefinitely; its data never reaches down_*.
REQ-025 down_valid low with down_ready low or high SHALL not alter state; stalls of any length are legal.
REQ-026 grant_id SHALL hold its last value in IDLE; grant_valid=0 in IDLE.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, rr=0, grant_id=0, line counter=0, drop_cnt=0, frame_done=0, sof_err=0.
REQ-028 During/after reset all readies and down_valid SHALL be 0 (IDLE decode).
REQ-029 Reset mid-frame SHALL abandon the frame; no frame_done issued for it.

Structure
REQ-030 Shared package video_pkg SHALL hold the FSM state enum and line-counter width function.
REQ-031 One sub-module SHALL be natural: axis_vid_mux (registered select, combinational 2:1 data/control mux with ready steering).
REQ-032 FSM, counters and rr pointer SHALL reside in top level; no storage of pixel data.

Verification (bench: FRAME_LINES=2, 4-pixel lines)
REQ-033 Only s0 sends 8-beat frame (tuser on beat 0, tlast beats 3,7) -> 8 beats on down_* unchanged, frame_done once, grant_id=0.
REQ-034 Both valid from reset -> s0 frame first, then s1 frame; alternation 0,1,0 over three frames each.
REQ-035 s1 sends 3 beats tuser=0 then valid frame -> drop_cnt=3, 8 beats forwarded starting at tuser beat.
REQ-036 tuser injected at beat 5 of s0 frame -> sof_err pulse, frame_done only after 2 further tlasts (beat 5 + 8 total beats).
REQ-037 Random down_ready 50% stall -> output sequence identical to unstalled run, no beat lost or duplicated.
REQ-038 rst_n low at beat 4 -> all readies/down_valid 0 immediately; after release, state IDLE, rr=0, drop_cnt=0.
